// File: rtl/sdhc_dat_rx.sv
// SD card DAT[3:0] block receiver: SDR/DDR50 capture, byte assembly, per-line CRC16
// checking, end-bit check, start-bit timeout and abort.
module sdhc_dat_rx (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  dat_i,
   input  logic        ddr_en_i,
   input  logic        start_i,
   input  logic [9:0]  blk_len_i,
   input  logic [15:0] timeout_i,
   input  logic        abort_i,
   output logic [7:0]  data_o,
   output logic        data_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        crc_err_o,
   output logic        end_err_o,
   output logic        timeout_o
);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StWaitStart = 3'd1;
   localparam logic [2:0] StData      = 3'd2;
   localparam logic [2:0] StCrc       = 3'd3;
   localparam logic [2:0] StEnd       = 3'd4;

   // Capture: pair_*_q holds {posedge sample, following negedge sample} of one card clock.
   logic [3:0] rise_q, fall_q, pair_rise_q, pair_fall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rise_q      <= 4'h0;
         pair_rise_q <= 4'h0;
         pair_fall_q <= 4'h0;
      end else begin
         rise_q      <= dat_i;
         pair_rise_q <= rise_q;
         pair_fall_q <= fall_q;
      end
   end

   always_ff @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fall_q <= 4'h0;
      end else begin
         fall_q <= dat_i;
      end
   end

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   logic [2:0]        state_q, state_d;
   logic              ddr_q, ddr_d;
   logic [9:0]        last_q, last_d;
   logic [15:0]       tmo_lim_q, tmo_lim_d;
   logic [15:0]       tmo_cnt_q, tmo_cnt_d;
   logic [9:0]        byte_cnt_q, byte_cnt_d;
   logic              phase_q, phase_d;
   logic [3:0]        crc_cnt_q, crc_cnt_d;
   logic [3:0]        nib_q, nib_d;
   logic [3:0][15:0]  crc_r_q, crc_r_d;
   logic [3:0][15:0]  crc_f_q, crc_f_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              crc_err_q, crc_err_d;
   logic              end_err_q, end_err_d;
   logic              tmo_q, tmo_d;
   logic              crc_mis;
   logic              byte_done;

   always_comb begin
      state_d    = state_q;
      ddr_d      = ddr_q;
      last_d     = last_q;
      tmo_lim_d  = tmo_lim_q;
      tmo_cnt_d  = tmo_cnt_q;
      byte_cnt_d = byte_cnt_q;
      phase_d    = phase_q;
      crc_cnt_d  = crc_cnt_q;
      nib_d      = nib_q;
      crc_r_d    = crc_r_q;
      crc_f_d    = crc_f_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      crc_err_d  = crc_err_q;
      end_err_d  = end_err_q;
      tmo_d      = 1'b0;
      crc_mis    = 1'b0;
      byte_done  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               state_d    = StWaitStart;
               ddr_d      = ddr_en_i;
               last_d     = (blk_len_i == 10'd0) ? 10'd511 : blk_len_i - 10'd1;
               tmo_lim_d  = timeout_i;
               tmo_cnt_d  = 16'd0;
               byte_cnt_d = 10'd0;
               phase_d    = 1'b0;
               crc_cnt_d  = 4'd0;
               crc_r_d    = '0;
               crc_f_d    = '0;
               crc_err_d  = 1'b0;
               end_err_d  = 1'b0;
            end
         end

         StWaitStart: begin
            if (pair_rise_q == 4'h0) begin
               state_d = StData;
            end else if (tmo_lim_q != 16'd0 && tmo_cnt_q + 16'd1 == tmo_lim_q) begin
               tmo_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         StData: begin
            for (int l = 0; l < 4; l++) begin
               crc_r_d[l] = crc16_step(crc_r_q[l], pair_rise_q[l]);
               if (ddr_q) begin
                  crc_f_d[l] = crc16_step(crc_f_q[l], pair_fall_q[l]);
               end
            end
            if (ddr_q) begin
               data_d    = {pair_rise_q, pair_fall_q};
               byte_done = 1'b1;
            end else if (!phase_q) begin
               nib_d   = pair_rise_q;
               phase_d = 1'b1;
            end else begin
               data_d    = {nib_q, pair_rise_q};
               phase_d   = 1'b0;
               byte_done = 1'b1;
            end
            if (byte_done) begin
               valid_d = 1'b1;
               if (byte_cnt_q == last_q) begin
                  state_d   = StCrc;
                  crc_cnt_d = 4'd0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 10'd1;
               end
            end
         end

         StCrc: begin
            // Compare MSB first, shifting each computed CRC out as it is checked.
            for (int l = 0; l < 4; l++) begin
               if (pair_rise_q[l] != crc_r_q[l][15]) crc_mis = 1'b1;
               crc_r_d[l] = {crc_r_q[l][14:0], 1'b0};
               if (ddr_q) begin
                  if (pair_fall_q[l] != crc_f_q[l][15]) crc_mis = 1'b1;
                  crc_f_d[l] = {crc_f_q[l][14:0], 1'b0};
               end
            end
            if (crc_mis) crc_err_d = 1'b1;
            crc_cnt_d = crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'd15) state_d = StEnd;
         end

         StEnd: begin
            if (pair_rise_q != 4'hF) end_err_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase

      if (abort_i && state_q != StIdle) begin
         state_d = StIdle;
         done_d  = 1'b0;
         tmo_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         ddr_q      <= 1'b0;
         last_q     <= 10'd0;
         tmo_lim_q  <= 16'd0;
         tmo_cnt_q  <= 16'd0;
         byte_cnt_q <= 10'd0;
         phase_q    <= 1'b0;
         crc_cnt_q  <= 4'd0;
         nib_q      <= 4'h0;
         crc_r_q    <= '0;
         crc_f_q    <= '0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         crc_err_q  <= 1'b0;
         end_err_q  <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ddr_q      <= ddr_d;
         last_q     <= last_d;
         tmo_lim_q  <= tmo_lim_d;
         tmo_cnt_q  <= tmo_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         phase_q    <= phase_d;
         crc_cnt_q  <= crc_cnt_d;
         nib_q      <= nib_d;
         crc_r_q    <= crc_r_d;
         crc_f_q    <= crc_f_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         crc_err_q  <= crc_err_d;
         end_err_q  <= end_err_d;
         tmo_q      <= tmo_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign crc_err_o    = crc_err_q;
   assign end_err_o    = end_err_q;
   assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_sdhc_dat_rx.sv
// Self-checking bench for sdhc_dat_rx: builds card-side DAT streams from random bytes and
// checks received bytes, strobe timing, CRC/end/timeout flags against a reference model.
`timescale 1ns/1ps
module tb_sdhc_dat_rx;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  dat_i = 4'hF;
   logic        ddr_en_i = 1'b0;
   logic        start_i = 1'b0;
   logic [9:0]  blk_len_i = 10'd0;
   logic [15:0] timeout_i = 16'd0;
   logic        abort_i = 1'b0;
   logic [7:0]  data_o;
   logic        data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o;

   sdhc_dat_rx dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .dat_i        (dat_i),
      .ddr_en_i     (ddr_en_i),
      .start_i      (start_i),
      .blk_len_i    (blk_len_i),
      .timeout_i    (timeout_i),
      .abort_i      (abort_i),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .crc_err_o    (crc_err_o),
      .end_err_o    (end_err_o),
      .timeout_o    (timeout_o)
   );

   always #10 clk_i = ~clk_i;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   int         cyc = 0;
   int         start_cyc = 0;
   int         sv_cyc[$];
   logic [7:0] sv_data[$];
   int         done_cyc[$];
   logic       done_crc[$];
   logic       done_end[$];
   int         tmo_cyc[$];
   logic       prev_tmo = 1'b0;
   logic       busy_after_tmo = 1'b1;

   always @(negedge clk_i) begin
      cyc <= cyc + 1;
      if (data_valid_o) begin
         sv_cyc.push_back(cyc + 1);
         sv_data.push_back(data_o);
      end
      if (done_o) begin
         done_cyc.push_back(cyc + 1);
         done_crc.push_back(crc_err_o);
         done_end.push_back(end_err_o);
      end
      if (timeout_o) tmo_cyc.push_back(cyc + 1);
      if (prev_tmo) busy_after_tmo <= busy_o;
      prev_tmo <= timeout_o;
   end

   task automatic clear_mon();
      sv_cyc.delete();
      sv_data.delete();
      done_cyc.delete();
      done_crc.delete();
      done_end.delete();
      tmo_cyc.delete();
      busy_after_tmo = 1'b1;
   endtask

   // One card clock: rise value sampled on posedge, fall value on the next negedge.
   task automatic drive_pair(input logic [3:0] r, input logic [3:0] f, input logic st);
      @(negedge clk_i);
      #5;
      dat_i   = r;
      start_i = st;
      @(posedge clk_i);
      if (st) start_cyc = cyc;
      #5;
      dat_i   = f;
      start_i = 1'b0;
   endtask

   // Reference stimulus and expectations.
   logic [3:0] st_r[$];
   logic [3:0] st_f[$];
   logic       st_s[$];
   logic [7:0] exp_bytes[$];
   logic       exp_crc, exp_end;
   int         sb_idx;

   // CRC16-CCITT as remainder of M(x)*x^16 modulo x^16+x^12+x^5+1.
   function automatic logic [15:0] ref_crc(input int line, input int sel, input bit ddr);
      logic [16:0] r;
      bit          bq[$];
      r = 17'h0;
      foreach (exp_bytes[i]) begin
         if (ddr) begin
            bq.push_back(sel == 0 ? exp_bytes[i][4+line] : exp_bytes[i][line]);
         end else begin
            bq.push_back(exp_bytes[i][4+line]);
            bq.push_back(exp_bytes[i][line]);
         end
      end
      for (int i = 0; i < 16; i++) bq.push_back(1'b0);
      foreach (bq[i]) begin
         r = {r[15:0], bq[i]};
         if (r[16]) r = r ^ 17'h11021;
      end
      return r[15:0];
   endfunction

   task automatic push(input logic [3:0] r, input logic [3:0] f, input logic s);
      st_r.push_back(r);
      st_f.push_back(f);
      st_s.push_back(s);
   endtask

   task automatic build_block(input bit ddr, input int n, input bit fixed, input int fl_line,
                              input int fl_sel, input int fl_bit, input logic [3:0] end_val);
      logic [15:0] cr[4];
      logic [15:0] cf[4];
      logic [3:0]  r, f;
      logic [7:0]  fixed_bytes[4];
      int          pre;
      st_r.delete();
      st_f.delete();
      st_s.delete();
      exp_bytes.delete();
      fixed_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      for (int i = 0; i < n; i++)
         exp_bytes.push_back(fixed ? fixed_bytes[i % 4] : 8'($urandom));
      for (int l = 0; l < 4; l++) begin
         cr[l] = ref_crc(l, 0, ddr);
         cf[l] = ref_crc(l, 1, ddr);
      end
      if (fl_line >= 0) begin
         if (fl_sel != 0) cf[fl_line][fl_bit] = ~cf[fl_line][fl_bit];
         else             cr[fl_line][fl_bit] = ~cr[fl_line][fl_bit];
      end
      exp_crc = (fl_line >= 0);
      exp_end = (end_val != 4'hF);
      push(4'hF, 4'hF, 1'b1);
      pre = int'($urandom_range(1, 3));
      for (int i = 0; i < pre; i++) push(4'hF, 4'hF, 1'b0);
      sb_idx = st_r.size();
      push(4'h0, 4'($urandom), 1'b0);
      foreach (exp_bytes[i]) begin
         if (ddr) begin
            push(exp_bytes[i][7:4], exp_bytes[i][3:0], 1'b0);
         end else begin
            push(exp_bytes[i][7:4], 4'($urandom), 1'b0);
            push(exp_bytes[i][3:0], 4'($urandom), 1'b0);
         end
      end
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < 4; l++) begin
            r[l] = cr[l][15-i];
            f[l] = cf[l][15-i];
         end
         push(r, ddr ? f : 4'($urandom), 1'b0);
      end
      push(end_val, ddr ? 4'hF : 4'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) push(4'hF, 4'hF, 1'b0);
   endtask

   task automatic run_stim(input int from, input int to);
      for (int i = from; i < to; i++) drive_pair(st_r[i], st_f[i], st_s[i]);
   endtask

   task automatic check_block(input string tag, input bit ddr);
      int n, nb;
      n  = exp_bytes.size();
      nb = sv_data.size();
      check_eq({tag, ".bytes"}, nb, n);
      for (int i = 0; i < n && i < nb; i++) begin
         check_eq({tag, ".data"}, sv_data[i], exp_bytes[i]);
         if (i > 0) check_eq({tag, ".gap"}, sv_cyc[i] - sv_cyc[i-1], ddr ? 1 : 2);
      end
      check_eq({tag, ".n_done"}, done_cyc.size(), 1);
      if (done_cyc.size() > 0 && nb > 0) begin
         check_eq({tag, ".done_lat"}, done_cyc[0] - sv_cyc[nb-1], 17);
         check_eq({tag, ".crc_err"}, done_crc[0], exp_crc);
         check_eq({tag, ".end_err"}, done_end[0], exp_end);
      end
      check_eq({tag, ".crc_hold"}, crc_err_o, exp_crc);
      check_eq({tag, ".end_hold"}, end_err_o, exp_end);
      check_eq({tag, ".n_tmo"}, tmo_cyc.size(), 0);
      check_eq({tag, ".busy_end"}, busy_o, 0);
   endtask

   task automatic do_block(input string tag, input bit ddr, input int len_code, input bit fixed,
                           input int fl_line, input int fl_sel, input int fl_bit,
                           input logic [3:0] end_val, input logic [15:0] tmo);
      int n;
      n = (len_code == 0) ? 512 : len_code;
      ddr_en_i  = ddr;
      blk_len_i = 10'(len_code);
      timeout_i = tmo;
      build_block(ddr, n, fixed, fl_line, fl_sel, fl_bit, end_val);
      clear_mon();
      run_stim(0, st_r.size());
      check_block(tag, ddr);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({data_o, data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_i);
      check_eq("reset_outs", all_outs(), 0);
      #5 rst_i = 1'b0;
      repeat (4) drive_pair(4'hF, 4'hF, 1'b0);

      do_block("sdr_fixed", 1'b0, 4, 1'b1, -1, 0, 0, 4'hF, 16'd0);
      do_block("ddr_fixed", 1'b1, 4, 1'b1, -1, 0, 0, 4'hF, 16'd0);
      do_block("ddr_crcflip", 1'b1, 4, 1'b1, 2, 1, 5, 4'hF, 16'd0);
      do_block("sdr_endbad", 1'b0, 4, 1'b1, -1, 0, 0, 4'hE, 16'd0);

      // Start-bit timeout: pulse expected timeout_i clocks after the start edge.
      clear_mon();
      ddr_en_i  = 1'b0;
      blk_len_i = 10'd4;
      timeout_i = 16'd10;
      drive_pair(4'hF, 4'hF, 1'b1);
      repeat (16) drive_pair(4'hF, 4'hF, 1'b0);
      check_eq("tmo.count", tmo_cyc.size(), 1);
      if (tmo_cyc.size() > 0) check_eq("tmo.lat", tmo_cyc[0] - start_cyc, 1 + 10);
      check_eq("tmo.busy_next", busy_after_tmo, 0);
      check_eq("tmo.no_done", done_cyc.size(), 0);

      // Abort mid-data, then start together with abort.
      ddr_en_i  = 1'b0;
      blk_len_i = 10'd8;
      timeout_i = 16'd0;
      build_block(1'b0, 8, 1'b0, -1, 0, 0, 4'hF);
      clear_mon();
      run_stim(0, sb_idx + 6);
      @(negedge clk_i);
      #5 abort_i = 1'b1;
      @(posedge clk_i);
      #5 abort_i = 1'b0;
      @(negedge clk_i);
      check_eq("abort.busy", busy_o, 0);
      run_stim(sb_idx + 6, st_r.size());
      check_eq("abort.no_done", done_cyc.size(), 0);
      @(negedge clk_i);
      #5;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge clk_i);
      #5;
      start_i = 1'b0;
      abort_i = 1'b0;
      @(negedge clk_i);
      check_eq("start_abort.busy", busy_o, 0);
      do_block("after_abort", 1'b1, 6, 1'b0, -1, 0, 0, 4'hF, 16'd0);

      // Reset after the second byte, then a clean block.
      ddr_en_i  = 1'b0;
      blk_len_i = 10'd4;
      build_block(1'b0, 4, 1'b0, -1, 0, 0, 4'hF);
      clear_mon();
      run_stim(0, sb_idx + 8);
      check_eq("rst_mid.bytes_before", sv_data.size(), 2);
      @(negedge clk_i);
      #5 rst_i = 1'b1;
      @(negedge clk_i);
      check_eq("rst_mid.outs0", all_outs(), 0);
      @(negedge clk_i);
      check_eq("rst_mid.outs1", all_outs(), 0);
      #5 rst_i = 1'b0;
      repeat (4) drive_pair(4'hF, 4'hF, 1'b0);
      check_eq("rst_mid.no_done", done_cyc.size(), 0);
      do_block("after_rst", 1'b0, 4, 1'b0, -1, 0, 0, 4'hF, 16'd0);

      do_block("ddr_len512", 1'b1, 0, 1'b0, -1, 0, 0, 4'hF, 16'd0);
      do_block("sdr_len512", 1'b0, 0, 1'b0, 1, 0, 0, 4'hF, 16'd300);

      for (int k = 0; k < 10; k++) begin
         bit          ddr;
         int          len, sel, fl_line, fl_sel, fl_bit;
         logic [3:0]  ev;
         ddr     = 1'($urandom);
         len     = int'($urandom_range(1, 40));
         sel     = int'($urandom_range(0, 3));
         fl_line = (sel == 1) ? int'($urandom_range(0, 3)) : -1;
         fl_sel  = ddr ? int'($urandom_range(0, 1)) : 0;
         fl_bit  = int'($urandom_range(0, 15));
         ev      = (sel == 2) ? 4'($urandom_range(0, 14)) : 4'hF;
         do_block("rand", ddr, len, 1'b0, fl_line, fl_sel, fl_bit, ev,
                  ($urandom_range(0, 1) != 0) ? 16'd0 : 16'd200);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdhc_dat_rx.md
SDHC_DAT_RX -- requirements
Module: sdhc_dat_rx

Interface
REQ-001 Port clk_i, input, 1: the only clock; pad card clock; both edges used only in the capture stage.
REQ-002 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-003 Port dat_i, input, 4: SD DAT[3:0] pad inputs.
REQ-004 Port ddr_en_i, input, 1: 1 = DDR50 (two samples per clock), 0 = SDR; sampled on start_i.
REQ-005 Port start_i, input, 1: one-cycle pulse that arms a block read; ignored while busy_o=1.
REQ-006 Port blk_len_i, input, 10: block length in bytes, 1..512 (0 means 512); sampled on start_i.
REQ-007 Port timeout_i, input, 16: start-bit wait limit in clocks; 0 disables it; sampled on start_i.
REQ-008 Port abort_i, input, 1: synchronous abort of the current read.
REQ-009 Port data_o, output, 8: received byte; first-transmitted nibble in [7:4].
REQ-010 Port data_valid_o, output, 1: one-cycle strobe that qualifies data_o; there is no backpressure.
REQ-011 Port busy_o, output, 1: high in any state other than IDLE.
REQ-012 Port done_o, output, 1: one-cycle pulse when the end-bit check completes.
REQ-013 Port crc_err_o, output, 1: CRC mismatch; valid with done_o and held until the next start_i.
REQ-014 Port end_err_o, output, 1: end bit not 1111; valid with done_o and held until the next start_i.
REQ-015 Port timeout_o, output, 1: one-cycle pulse when the start bit did not arrive in time.

Function
REQ-016 Capture stage: rise_q registers dat_i on posedge; fall_q registers dat_i on negedge; fall_q is re-registered on posedge so that {rise, fall} is an aligned pair available at each posedge.
REQ-017 The FSM has five states: IDLE, WAIT_START, DATA, CRC, END.
  - It consumes one aligned pair per clock.
  - In SDR mode only rise is used.
REQ-018 IDLE -> WAIT_START on start_i.
  - The timeout counter clears.
  - crc_err_o and end_err_o clear.
REQ-019 WAIT_START -> DATA on the first cycle with rise==4'b0000 (the start bit).
  - In DDR mode, fall of the start cycle is ignored.
REQ-020 WAIT_START timeout: when timeout_i!=0 and the counter reaches timeout_i, assert timeout_o for one cycle and go to IDLE.
REQ-021 DATA lasts 2*blk_len cycles in SDR and blk_len cycles in DDR.
  - SDR: the byte is {first nibble, second nibble}.
  - DDR: the byte is {rise, fall}.
REQ-022 Byte output: data_valid_o pulses on the clock after each byte completes.
  - SDR gives one strobe per 2 cycles.
  - DDR gives strobes on consecutive cycles.
REQ-023 CRC engines: one CRC16-CCITT (x^16+x^12+x^5+1, init 0) per line.
  - SDR uses 4 engines.
  - DDR uses 8 engines, separate for rise and fall samples.
  - The CRC covers DATA bits only.
REQ-024 CRC lasts 16 cycles in both modes; the received CRC arrives MSB first, per line, per edge.
  - Any bit mismatch sets crc_err_o.
REQ-025 END lasts 1 cycle.
  - If rise != 4'b1111, set end_err_o.
  - Assert done_o, then go to IDLE.
REQ-026 abort_i in any non-IDLE state returns the FSM to IDLE on the next clock.
  - It produces no done_o or timeout_o.
  - A data_valid_o for a byte already completed still issues.
REQ-027 start_i in the same cycle as abort_i is ignored.
REQ-028 A start bit seen while in DATA/CRC/END is treated as data; there is no resynchronisation.
REQ-029 blk_len_i=0 receives 512 bytes.
  - The byte counter is 10 bits plus a phase bit; it is compared, not wrapped.

Reset
REQ-030 While rst_i=1, the FSM enters IDLE and all capture flops, counters and CRC registers are 0.
  - data_o=8'h00; data_valid_o, busy_o, done_o, crc_err_o, end_err_o and timeout_o are 0.
REQ-031 Reset asserted mid-block discards the block and no done_o is produced; operation resumes from IDLE on the first posedge after release.

Verification
REQ-032 SDR, blk_len=4, bytes A5 3C FF 00, correct CRCs -> four strobes with A5, 3C, FF, 00, two cycles apart; done_o 17 cycles after the last data cycle; both error flags 0.
REQ-033 DDR, same bytes, correct per-edge CRCs -> four strobes on consecutive cycles; done_o; no errors.
REQ-034 DDR, line 2 falling-edge CRC bit 5 flipped -> all 4 bytes delivered; done_o with crc_err_o=1, end_err_o=0.
REQ-035 SDR, end bit 1110 -> done_o with end_err_o=1, crc_err_o=0.
REQ-036 timeout_i=10, dat_i held 1111 -> timeout_o pulse 10 cycles after start_i; busy_o=0 the next cycle; no done_o.
REQ-037 rst_i asserted after the 2nd byte, then released, then a valid SDR block -> outputs 0 during reset; the new block is received correctly with no stale bytes.
